// File: rtl/button_pkg.sv
// Shared types and board-clock defaults for the push-button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 10 ms debounce and 1 s hold at a 50 MHz board clock.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500_000;
    localparam int unsigned LONG_CYCLES_DEF     = 50_000_000;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_sync.sv
// Generic multi-flop synchroniser for one asynchronous pin, cleared to 0 in reset.
module button_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchroniser, debounce FSM, press/release pulses.
// Optional hold detection on LongPress is built when BUTTON_LONG_PRESS_EN is defined.
//
// state        | meaning
// IDLE         | stable released
// PRESS_WAIT   | candidate press, counting stable high samples
// PRESSED      | stable pressed
// RELEASE_WAIT | candidate release, counting stable low samples
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic Clk,
    input  logic nReset,
    input  logic Button,
    output logic Level,
    output logic Press,
    output logic Release,
    output logic LongPress
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    btn_state_t    state;
    btn_state_t    state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          level_nxt;
    logic          press_nxt;
    logic          release_nxt;
    logic          s;

    button_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (Clk),
        .rst_n (nReset),
        .d     (Button),
        .q     (s)
    );

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state   <= IDLE;
            count   <= '0;
            Level   <= 1'b0;
            Press   <= 1'b0;
            Release <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            Level   <= level_nxt;
            Press   <= press_nxt;
            Release <= release_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         if (s) state_nxt = PRESS_WAIT;
            PRESS_WAIT: begin
                if (!s)                  state_nxt = IDLE;
                else if (count == DB_LAST) state_nxt = PRESSED;
            end
            PRESSED:      if (!s) state_nxt = RELEASE_WAIT;
            RELEASE_WAIT: begin
                if (s)                   state_nxt = PRESSED;
                else if (count == DB_LAST) state_nxt = IDLE;
            end
            default:      state_nxt = IDLE;
        endcase
    end

    // Count returns to 0 whenever the candidate is accepted or rejected, so it never wraps.
    always_comb begin
        count_nxt   = count;
        level_nxt   = Level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            PRESS_WAIT: begin
                if (!s) begin
                    count_nxt = '0;
                end else if (count == DB_LAST) begin
                    count_nxt = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    count_nxt = '0;
                end else if (count == DB_LAST) begin
                    count_nxt   = '0;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            default: count_nxt = '0;
        endcase
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int unsigned HW = cnt_width(LONG_CYCLES);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold;
    logic          hold_done;

    // Hold count lives only while PRESSED; any other state re-arms it for the next entry.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            hold      <= '0;
            hold_done <= 1'b0;
            LongPress <= 1'b0;
        end else begin
            LongPress <= 1'b0;
            if (state != PRESSED) begin
                hold      <= '0;
                hold_done <= 1'b0;
            end else if (!hold_done) begin
                if (hold == LONG_LAST) begin
                    hold_done <= 1'b1;
                    LongPress <= 1'b1;
                end else begin
                    hold <= hold + 1'b1;
                end
            end
        end
    end
`else
    assign LongPress = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_button_debouncer;
    import button_pkg::*;

`ifdef BUTTON_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic Clk;
    logic nReset;
    logic Button;
    logic Level;
    logic Press;
    logic Release;
    logic LongPress;

    int checks;
    int errors;

    button_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (10)
    ) dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .Button    (Button),
        .Level     (Level),
        .Press     (Press),
        .Release   (Release),
        .LongPress (LongPress)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic test_reset();
        nReset = 1'b0;
        Button = 1'b1;
        #2;
        checks++;
        if ({Level, Press, Release, LongPress} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000", {Level, Press, Release, LongPress});
        end
        repeat (3) @(negedge Clk);
        checks++;
        if ({Level, Press, Release, LongPress} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: got %b expected 0000", {Level, Press, Release, LongPress});
        end
        nReset = 1'b1;
        for (int e = 0; e < 8; e++) begin
            @(posedge Clk);
            @(negedge Clk);
            checks++;
            if (Level !== (e >= 6)) begin
                errors++;
                $display("FAIL first_press_level edge %0d: got %b expected %b", e, Level, (e >= 6));
            end
            checks++;
            if (Press !== (e == 6)) begin
                errors++;
                $display("FAIL first_press_pulse edge %0d: got %b expected %b", e, Press, (e == 6));
            end
        end
    endtask

    // Continues counting edges from the press (edge 6) while the button stays down.
    task automatic test_long_press();
        for (int e = 8; e < 30; e++) begin
            @(posedge Clk);
            @(negedge Clk);
            checks++;
            if ({Level, Press, Release} !== 3'b100) begin
                errors++;
                $display("FAIL hold_level edge %0d: got %b expected 100", e, {Level, Press, Release});
            end
            checks++;
            if (LongPress !== (LONG_EN && (e == 16))) begin
                errors++;
                $display("FAIL long_press edge %0d: got %b expected %b", e, LongPress, (LONG_EN && (e == 16)));
            end
        end
    endtask

    task automatic test_release();
        Button = 1'b0;
        for (int e = 0; e < 8; e++) begin
            @(posedge Clk);
            @(negedge Clk);
            checks++;
            if (Level !== (e < 6)) begin
                errors++;
                $display("FAIL release_level edge %0d: got %b expected %b", e, Level, (e < 6));
            end
            checks++;
            if ({Press, Release} !== {1'b0, (e == 6)}) begin
                errors++;
                $display("FAIL release_pulse edge %0d: got %b expected %b", e, {Press, Release}, {1'b0, (e == 6)});
            end
        end
    endtask

    task automatic test_bounce();
        logic [13:0] pat;
        pat = 14'b00000001110111;
        for (int i = 0; i < 14; i++) begin
            Button = pat[i];
            @(posedge Clk);
            @(negedge Clk);
            checks++;
            if ({Level, Press, Release} !== 3'b000) begin
                errors++;
                $display("FAIL bounce edge %0d: got %b expected 000", i, {Level, Press, Release});
            end
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL bounce_state: got %0d expected %0d", dut.state, IDLE);
        end
    endtask

    task automatic test_release_bounce();
        Button = 1'b1;
        repeat (8) begin
            @(posedge Clk);
            @(negedge Clk);
        end
        checks++;
        if (Level !== 1'b1) begin
            errors++;
            $display("FAIL rb_setup_level: got %b expected 1", Level);
        end
        for (int e = 0; e < 10; e++) begin
            Button = (e >= 2);
            @(posedge Clk);
            @(negedge Clk);
            checks++;
            if ({Level, Press, Release} !== 3'b100) begin
                errors++;
                $display("FAIL rb_hold edge %0d: got %b expected 100", e, {Level, Press, Release});
            end
        end
        checks++;
        if (dut.state !== PRESSED) begin
            errors++;
            $display("FAIL rb_state: got %0d expected %0d", dut.state, PRESSED);
        end
        Button = 1'b0;
        for (int e = 0; e < 8; e++) begin
            @(posedge Clk);
            @(negedge Clk);
            checks++;
            if ({Level, Release} !== {(e < 6), (e == 6)}) begin
                errors++;
                $display("FAIL rb_release edge %0d: got %b expected %b", e, {Level, Release}, {(e < 6), (e == 6)});
            end
        end
    endtask

    task automatic test_async_reset();
        Button = 1'b1;
        repeat (5) begin
            @(posedge Clk);
            @(negedge Clk);
        end
        checks++;
        if ({dut.state, dut.count} !== {PRESS_WAIT, 2'd2}) begin
            errors++;
            $display("FAIL ar_precond: got state %0d count %0d expected state %0d count 2", dut.state, dut.count, PRESS_WAIT);
        end
        #1;
        nReset = 1'b0;
        #1;
        checks++;
        if ({Level, Press, Release, LongPress} !== 4'b0000) begin
            errors++;
            $display("FAIL ar_outputs: got %b expected 0000", {Level, Press, Release, LongPress});
        end
        checks++;
        if ({dut.state, dut.count, dut.s} !== {IDLE, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL ar_internal: got state %0d count %0d s %b expected 0 0 0", dut.state, dut.count, dut.s);
        end
        @(negedge Clk);
        nReset = 1'b1;
        for (int e = 0; e < 8; e++) begin
            @(posedge Clk);
            @(negedge Clk);
            checks++;
            if ({Level, Press} !== {(e >= 6), (e == 6)}) begin
                errors++;
                $display("FAIL ar_repress edge %0d: got %b expected %b", e, {Level, Press}, {(e >= 6), (e == 6)});
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nReset = 1'b0;
        Button = 1'b0;
        test_reset();
        test_long_press();
        test_release();
        test_bounce();
        test_release_bounce();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
